// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Holds the default width, the widest legal result type and a plain
// arithmetic reference function for {cout, s}.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 4;
  localparam int FA_MAX_WIDTH     = 64;

  // Wide enough for {cout, s} at the largest legal width.
  // A WIDTH-bit instance uses only bits [WIDTH:0].
  typedef logic [FA_MAX_WIDTH:0] fa_result_t;

  // Exact a + b + cin for zero-extended operands; slice [WIDTH:0] for {cout, s}.
  function automatic fa_result_t fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                        input logic [FA_MAX_WIDTH-1:0] b,
                                        input logic                    cin);
    return fa_result_t'(a) + fa_result_t'(b) + fa_result_t'(cin);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell: the building block of the ripple-carry chain.
module fa_bit (
  output logic co,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic ci
);

  // Sum is the parity of the three inputs; carry propagates when a^b is set.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin, one clock of latency.
// A chain of fa_bit cells forms the combinational carry path, LSB to MSB,
// with no lookahead. Results and the valid flag are registered here.
// Optional feature: define FULL_ADDER_OVF_EN to add a registered signed
// overflow output ovf = c[WIDTH] ^ c[WIDTH-1].
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      fa_bit u_cell (
        .co (carry[i+1]),
        .s  (sum_bits[i]),
        .a  (a[i]),
        .b  (b[i]),
        .ci (carry[i])
      );
    end
  endgenerate

  // Capture the chain result on valid cycles; hold it otherwise, and pulse out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_bits;
        cout <= carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=4 and WIDTH=1.
// An arithmetic model predicts every registered output each cycle; a few
// directed vectors also carry hand-computed literal results.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid4, cin4, out_valid4, cout4;
  logic [3:0] a4, b4, s4;
  logic       in_valid1, cin1, out_valid1, cout1;
  logic [0:0] a1, b1, s1;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf4, ovf1;
`endif

  // Model state
  logic       exp_valid4 = 1'b0, exp_cout4 = 1'b0, exp_ovf4 = 1'b0;
  logic [3:0] exp_s4 = 4'h0;
  logic       exp_valid1 = 1'b0, exp_cout1 = 1'b0, exp_ovf1 = 1'b0;
  logic [0:0] exp_s1 = 1'b0;

  // Hand-computed literal expectations armed by the stimulus
  logic       lit_armed = 1'b0, lit_cout = 1'b0, lit_ovf = 1'b0;
  logic [3:0] lit_s = 4'h0;
  logic       due_armed = 1'b0, due_cout = 1'b0, due_ovf = 1'b0;
  logic [3:0] due_s = 4'h0;

  logic       check_en = 1'b0;
  event       check_now;
  int         test_count = 0;
  int         fail_count = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .s         (s4),
    .cout      (cout4)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  full_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .s         (s1),
    .cout      (cout1)
`ifdef FULL_ADDER_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  // Behavioural model: exact integer sum, signed range test for overflow
  always @(posedge clk or negedge rst_n) begin : model
    int sum, ssum;
    if (!rst_n) begin
      exp_valid4 = 1'b0; exp_s4 = 4'h0; exp_cout4 = 1'b0; exp_ovf4 = 1'b0;
      exp_valid1 = 1'b0; exp_s1 = 1'b0; exp_cout1 = 1'b0; exp_ovf1 = 1'b0;
      due_armed  = 1'b0;
    end else begin
      exp_valid4 = in_valid4;
      if (in_valid4) begin
        sum       = int'(a4) + int'(b4) + int'(cin4);
        exp_s4    = 4'(sum % 16);
        exp_cout4 = (sum >= 16);
        ssum      = (a4[3] ? int'(a4) - 16 : int'(a4)) +
                    (b4[3] ? int'(b4) - 16 : int'(b4)) + int'(cin4);
        exp_ovf4  = (ssum > 7) || (ssum < -8);
      end
      exp_valid1 = in_valid1;
      if (in_valid1) begin
        sum       = int'(a1) + int'(b1) + int'(cin1);
        exp_s1    = 1'(sum % 2);
        exp_cout1 = (sum >= 2);
        ssum      = (a1[0] ? -1 : 0) + (b1[0] ? -1 : 0) + int'(cin1);
        exp_ovf1  = (ssum > 0) || (ssum < -1);
      end
      due_armed = lit_armed && in_valid4;
      due_s     = lit_s;
      due_cout  = lit_cout;
      due_ovf   = lit_ovf;
    end
  end

  task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("dut4 out_valid", 64'(out_valid4), 64'(exp_valid4));
    checkOne("dut4 s",         64'(s4),         64'(exp_s4));
    checkOne("dut4 cout",      64'(cout4),      64'(exp_cout4));
    checkOne("dut1 out_valid", 64'(out_valid1), 64'(exp_valid1));
    checkOne("dut1 s",         64'(s1),         64'(exp_s1));
    checkOne("dut1 cout",      64'(cout1),      64'(exp_cout1));
`ifdef FULL_ADDER_OVF_EN
    checkOne("dut4 ovf",       64'(ovf4),       64'(exp_ovf4));
    checkOne("dut1 ovf",       64'(ovf1),       64'(exp_ovf1));
`endif
    if (due_armed) begin
      checkOne("literal s",    64'(s4),         64'(due_s));
      checkOne("literal cout", 64'(cout4),      64'(due_cout));
`ifdef FULL_ADDER_OVF_EN
      checkOne("literal ovf",  64'(ovf4),       64'(due_ovf));
`endif
    end
  endtask

  // Compare process: every falling edge, plus on demand right after async reset
  always begin
    @(negedge clk or check_now);
    if (check_en) checkOutput();
  end

  // Drive one WIDTH=4 cycle just after a falling edge; return at the next one
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic c, input logic armed, input logic [3:0] ls,
                               input logic lc, input logic lo);
    #1;
    in_valid4 = v; a4 = a; b4 = b; cin4 = c;
    lit_armed = armed; lit_s = ls; lit_cout = lc; lit_ovf = lo;
    @(negedge clk);
  endtask

  task automatic applyStimulus1(input logic v, input logic [2:0] abc);
    #1;
    in_valid1 = v; a1 = abc[2]; b1 = abc[1]; cin1 = abc[0];
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000; cin4 = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    check_en = 1'b1;
    repeat (3) @(negedge clk);

    // Release reset with a valid vector still applied: 1111+0000+0
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);

    // Directed vectors with hand-computed results
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1010, 4'b1010, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1010, 4'b1010, 1'b1, 1'b1, 4'b0101, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1110, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0101, 4'b0010, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1);

    // Idle: outputs hold, out_valid low
    applyStimulus(1'b0, 4'b0011, 4'b0011, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Reset mid-operation: result captured, then discarded asynchronously
    #1;
    in_valid4 = 1'b1; a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b0; lit_armed = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 -> check_now;
    @(negedge clk);
    #1 rst_n = 1'b1;
    in_valid4 = 1'b0;
    @(negedge clk);

    // Streaming: 16 back-to-back random vectors, then two idle cycles
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'b0, 4'h0, 1'b0, 1'b0);
    end
    repeat (2) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

    // WIDTH=1 exhaustive, back to back, then idle
    for (int i = 0; i < 8; i++) applyStimulus1(1'b1, 3'(i));
    repeat (2) applyStimulus1(1'b0, 3'b000);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry adder: computes a + b + cin over WIDTH bits and produces sum s and carry-out cout.
- Built from a chain of 1-bit full-adder cells.
- The WIDTH=1 instance is the basic cell-level adder; the WIDTH=4 instance is the nibble adder used by the datapath.
- Inputs are captured and the result is registered, so result and carry appear one clock after a valid input.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b/cin valid this cycle.
- a  input  WIDTH  operand A, unsigned, bit 0 = LSB.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  s/cout hold a fresh result.
- s  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB cell.

Behaviour:
- Reset: rst_n low asserts immediately, without waiting for clk. While low, s=0, cout=0, out_valid=0.
- Reset release is synchronised by use: the first capture occurs on the first rising clk edge with rst_n high.
- Bit-cell equations: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin; cout = c_WIDTH.
- Carry chain is purely combinational, LSB to MSB, with no lookahead.
- Latency: on a rising edge with in_valid=1, s and cout load the sum of that cycle's inputs, and out_valid goes to 1 for exactly the following cycle.
- On a rising edge with in_valid=0, out_valid goes to 0 and s/cout hold their previous values.
- Back-to-back operation: in_valid may stay high every cycle. Throughput is one result per clock, with no stall and no backpressure.
- Wrap-around: the full result {cout, s} = a + b + cin is exact (WIDTH+1 bits). All-ones + all-ones + 1 gives s = all-ones, cout = 1.
- X-handling: cin must be driven. Users tie cin to 0 when unused; the block does not default it.
- Reset mid-operation: an in-flight result is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered alongside s) = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement signed overflow.
  - ovf resets to 0 and holds when in_valid=0.
  - For WIDTH=1, ovf = cout ^ cin.
- When undefined: port ovf is absent and no logic is generated.

Decomposition:
- Package full_adder_pkg:
  - localparam FA_DEFAULT_WIDTH = 4;
  - typedef for the WIDTH+1 result vector helper;
  - function fa_ref(a, b, cin) returning {cout, s} for verification.
- One sub-module, fa_bit:
  - 1-bit combinational cell with ports (co, s, a, b, ci), instantiated WIDTH times in a generate loop.
- Output registers and the valid flop live in full_adder.

Test Plan:
- Reset: rst_n=0 with in_valid=1, a=4'b1111 -> s=0000, cout=0, out_valid=0 throughout. Release, then one valid cycle -> out_valid=1 next cycle.
- Zero add: a=0000, b=0000, cin=0, in_valid=1 -> next cycle s=0000, cout=0.
- Carry out: a=1010, b=1010, cin=0 -> s=0100, cout=1. With cin=1 -> s=0101, cout=1.
- Mixed: a=1110, b=0011, cin=0 -> s=0001, cout=1. Also a=0101, b=0010, cin=1 -> s=1000, cout=0.
- Wrap: a=1111, b=1111, cin=0 -> s=1110, cout=1. With cin=1 -> s=1111, cout=1. Under FULL_ADDER_OVF_EN, a=0111, b=0001 -> ovf=1.
- Streaming: 16 consecutive random valid vectors, then in_valid=0 for 2 cycles -> every result matches fa_ref one cycle later; outputs hold and out_valid=0 when idle; repeat at WIDTH=1 exhaustively (8 combos).
